instruction_fetch: RTL

Fetch stage that sits directly upstream of the control unit in the single-issue datapath. It holds the PC, fetches 32-bit instructions from instruction memory over a req/ack handshake, and latches each word in an instruction register. It presents the split fields (OPcode, rs, rt, rd, shamt, funct) to decode and control with a valid/ready handshake. Redirect support lets later branch/jump logic retarget the PC.

---
 rtl/instruction_fetch_if.sv | 34 +++
 rtl/instruction_fetch.sv | 108 ++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port, decode valid/ready
// port with split fields, and the redirect input from branch/jump logic.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              id_ready;
  logic              id_valid;
  logic [31:0]       instr;
  logic [5:0]        OPcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [ADDR_W-1:0] pc_out;
  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_pc;

  // fetch unit side
  modport master (
    output mem_req, mem_addr, id_valid, instr, OPcode, rs, rt, rd, shamt, funct, pc_out,
    input  mem_ack, mem_rdata, id_ready, redirect_en, redirect_pc
  );

  // memory / decode / branch side
  modport slave (
    input  mem_req, mem_addr, id_valid, instr, OPcode, rs, rt, rd, shamt, funct, pc_out,
    output mem_ack, mem_rdata, id_ready, redirect_en, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, req/ack fetch from instruction memory, instruction
// register with valid/ready hand-off to decode, and PC redirect.
module instruction_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t               state, state_d;
  logic [ADDR_W-1:0]    pc, pc_d;
  logic [ADDR_W-1:0]    pc_out_q, pc_out_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [OP_W-1:0]      opcode_q, opcode_d;
  logic                 id_valid_q, id_valid_d;
  logic                 mem_req_q, mem_req_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and next register values; redirect overrides ack and ready.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    pc_out_d   = pc_out_q;
    instr_d    = instr_q;
    id_valid_d = id_valid_q;
    mem_req_d  = mem_req_q;
    if (bus.redirect_en) begin
      pc_d       = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      id_valid_d = 1'b0;
      mem_req_d  = 1'b1;
      state_d    = REQ;
    end else begin
      unique case (state)
        IDLE: begin
          mem_req_d = 1'b1;
          state_d   = REQ;
        end
        REQ: begin
          if (bus.mem_ack) begin
            instr_d    = bus.mem_rdata;
            pc_out_d   = pc;
            pc_d       = pc + ADDR_W'(PC_STEP);
            id_valid_d = 1'b1;
            mem_req_d  = 1'b0;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (bus.id_ready) begin
            id_valid_d = 1'b0;
            mem_req_d  = 1'b1;
            state_d    = REQ;
          end
        end
        default: begin
          id_valid_d = 1'b0;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end
      endcase
    end
    // All-ones opcode steers control into its default word while nothing is valid
    opcode_d = id_valid_d ? instr_d[31:26] : {OP_W{1'b1}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      pc_out_q   <= '0;
      instr_q    <= '0;
      opcode_q   <= {OP_W{1'b1}};
      id_valid_q <= 1'b0;
      mem_req_q  <= 1'b0;
    end else begin
      pc         <= pc_d;
      pc_out_q   <= pc_out_d;
      instr_q    <= instr_d;
      opcode_q   <= opcode_d;
      id_valid_q <= id_valid_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = pc;
  assign bus.id_valid = id_valid_q;
  assign bus.instr    = instr_q;
  assign bus.OPcode   = opcode_q;
  assign bus.rs       = instr_q[25:21];
  assign bus.rt       = instr_q[20:16];
  assign bus.rd       = instr_q[15:11];
  assign bus.shamt    = instr_q[10:6];
  assign bus.funct    = instr_q[5:0];
  assign bus.pc_out   = pc_out_q;

endmodule
